// File: rtl/reward_qtable_pkg.sv
// Shared types and constants for the reward/Q-table routing stage.
// Packet-type encodings, the FSM state type and the update-type filter helper.
package reward_qtable_pkg;

    localparam int PKT_HB  = 1;
    localparam int PKT_ACK = 3;

    localparam logic [7:0] DEFAULT_TYPE_MASK = 8'((1 << PKT_HB) | (1 << PKT_ACK));

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        UPDATE,
        BEST,
        DONE
    } rq_state_e;

    function automatic logic typeEnabled(input logic [7:0] mask, input logic [2:0] pktType);
        return mask[pktType];
    endfunction

endpackage

// File: rtl/reward_qtable_if.sv
// Packet handshake plus published best-next-hop bus of the reward/Q-table stage.
interface reward_qtable_if #(
    parameter int WW            = 16,
    parameter int NUM_NEIGHBORS = 8
);
    localparam int IW = $clog2(NUM_NEIGHBORS);

    logic          pktValid;
    logic          pktReady;
    logic [2:0]    fPacketType;
    logic [WW-1:0] srcID;
    logic [WW-1:0] srcEnergy;
    logic [WW-1:0] srcHops;
    logic [WW-1:0] srcQ;
    logic          srcLowE;
    logic          updDone;
    logic          updDrop;
    logic          bestValid;
    logic [WW-1:0] bestID;
    logic [WW-1:0] bestQ;
    logic [IW:0]   numValid;
    logic          tblFull;

    modport master (
        output pktValid, fPacketType, srcID, srcEnergy, srcHops, srcQ, srcLowE,
        input  pktReady, updDone, updDrop, bestValid, bestID, bestQ, numValid, tblFull
    );

    modport slave (
        input  pktValid, fPacketType, srcID, srcEnergy, srcHops, srcQ, srcLowE,
        output pktReady, updDone, updDrop, bestValid, bestID, bestQ, numValid, tblFull
    );

endinterface

// File: rtl/reward_qtable_qcalc.sv
// Combinational EER-RL datapath: reward from energy/hops, saturated target, and the
// Q-update with a floor-rounding arithmetic shift so the result never leaves [0, 2^WW-1].
module reward_qcalc #(
    parameter int WW          = 16,
    parameter int E_SHIFT     = 4,
    parameter int HOP_SHIFT   = 3,
    parameter int ALPHA_SHIFT = 1
) (
    input  logic [WW-1:0] srcEnergy_i,
    input  logic [WW-1:0] srcHops_i,
    input  logic [WW-1:0] srcQ_i,
    input  logic          srcLowE_i,
    input  logic [WW-1:0] qOld_i,
    output logic [WW-1:0] qNew_o
);
    localparam logic [WW-1:0] MAX_WORD = '1;

    logic [WW-1:0]           eTerm;
    logic [WW-1:0]           hTerm;
    logic [WW+HOP_SHIFT-1:0] hopWide;
    logic [WW-1:0]           reward;
    logic [WW:0]             targetSum;
    logic [WW-1:0]           target;
    logic signed [WW+1:0]    diff;
    logic signed [WW+1:0]    step;
    logic signed [WW+1:0]    qSum;
    logic                    unusedTopBits;

    always_comb begin
        eTerm   = srcEnergy_i >> E_SHIFT;
        hopWide = (WW+HOP_SHIFT)'(srcHops_i) << HOP_SHIFT;
        hTerm   = (hopWide > (WW+HOP_SHIFT)'(MAX_WORD)) ? MAX_WORD : hopWide[WW-1:0];

        if (srcLowE_i || (eTerm <= hTerm)) begin
            reward = '0;
        end else begin
            reward = eTerm - hTerm;
        end

        targetSum = {1'b0, reward} + {1'b0, srcQ_i};
        target    = targetSum[WW] ? MAX_WORD : targetSum[WW-1:0];

        // Floor rounding keeps qNew >= target when moving down, so it cannot go negative
        diff   = $signed({2'b00, target}) - $signed({2'b00, qOld_i});
        step   = diff >>> ALPHA_SHIFT;
        qSum   = $signed({2'b00, qOld_i}) + step;
        qNew_o = qSum[WW-1:0];
    end

    assign unusedTopBits = ^qSum[WW+1:WW];

endmodule

// File: rtl/reward_qtable.sv
// Neighbour Q-table: per packet it searches/updates one entry, then rescans the
// whole table and publishes the best next hop. Table lives in flops.
module reward_qtable
    import reward_qtable_pkg::*;
#(
    parameter int                    NUM_NEIGHBORS    = 8,
    parameter int                    WORD_WIDTH       = 16,
    parameter int                    E_SHIFT          = 4,
    parameter int                    HOP_SHIFT        = 3,
    parameter int                    ALPHA_SHIFT      = 1,
    parameter logic [WORD_WIDTH-1:0] INIT_Q           = '0,
    parameter logic [7:0]            UPDATE_TYPE_MASK = DEFAULT_TYPE_MASK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  tblClear_i,
    input  logic [WORD_WIDTH-1:0] myNodeID_i,
    reward_qtable_if.slave        bus
);
    localparam int IW = $clog2(NUM_NEIGHBORS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NEIGHBORS - 1);
    localparam logic [CW-1:0] SCAN_END = CW'(NUM_NEIGHBORS);

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] q;
    } nbr_entry_t;

    rq_state_e             stateQ, stateD;
    logic                  armedQ;
    nbr_entry_t            tblQ [NUM_NEIGHBORS];
    nbr_entry_t            tblD [NUM_NEIGHBORS];
    logic [CW-1:0]         cntQ, cntD;
    logic [WORD_WIDTH-1:0] srcIDQ, srcIDD;
    logic [WORD_WIDTH-1:0] srcEnergyQ, srcEnergyD;
    logic [WORD_WIDTH-1:0] srcHopsQ, srcHopsD;
    logic [WORD_WIDTH-1:0] srcQQ, srcQD;
    logic                  srcLowEQ, srcLowED;
    logic                  hitQ, hitD;
    logic                  freeFoundQ, freeFoundD;
    logic [IW-1:0]         slotQ, slotD;
    logic                  dropQ, dropD;
    logic                  runValidQ, runValidD;
    logic [WORD_WIDTH-1:0] runIDQ, runIDD;
    logic [WORD_WIDTH-1:0] runQvalQ, runQvalD;
    logic [CW-1:0]         runCntQ, runCntD;
    logic                  bestValidQ, bestValidD;
    logic [WORD_WIDTH-1:0] bestIDQ, bestIDD;
    logic [WORD_WIDTH-1:0] bestQQ, bestQD;
    logic [CW-1:0]         numValidQ, numValidD;

    logic [IW-1:0]         idx;
    nbr_entry_t            curEntry;
    logic [WORD_WIDTH-1:0] qOld;
    logic [WORD_WIDTH-1:0] qNew;
    logic                  accept;

    assign accept = bus.pktValid && bus.pktReady;
    assign idx    = cntQ[IW-1:0];

    reward_qcalc #(
        .WW          (WORD_WIDTH),
        .E_SHIFT     (E_SHIFT),
        .HOP_SHIFT   (HOP_SHIFT),
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) uQcalc (
        .srcEnergy_i (srcEnergyQ),
        .srcHops_i   (srcHopsQ),
        .srcQ_i      (srcQQ),
        .srcLowE_i   (srcLowEQ),
        .qOld_i      (qOld),
        .qNew_o      (qNew)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            armedQ     <= 1'b0;
            tblQ       <= '{default: '0};
            cntQ       <= '0;
            srcIDQ     <= '0;
            srcEnergyQ <= '0;
            srcHopsQ   <= '0;
            srcQQ      <= '0;
            srcLowEQ   <= 1'b0;
            hitQ       <= 1'b0;
            freeFoundQ <= 1'b0;
            slotQ      <= '0;
            dropQ      <= 1'b0;
            runValidQ  <= 1'b0;
            runIDQ     <= '0;
            runQvalQ   <= '0;
            runCntQ    <= '0;
            bestValidQ <= 1'b0;
            bestIDQ    <= '0;
            bestQQ     <= '0;
            numValidQ  <= '0;
        end else begin
            stateQ     <= stateD;
            armedQ     <= 1'b1;
            tblQ       <= tblD;
            cntQ       <= cntD;
            srcIDQ     <= srcIDD;
            srcEnergyQ <= srcEnergyD;
            srcHopsQ   <= srcHopsD;
            srcQQ      <= srcQD;
            srcLowEQ   <= srcLowED;
            hitQ       <= hitD;
            freeFoundQ <= freeFoundD;
            slotQ      <= slotD;
            dropQ      <= dropD;
            runValidQ  <= runValidD;
            runIDQ     <= runIDD;
            runQvalQ   <= runQvalD;
            runCntQ    <= runCntD;
            bestValidQ <= bestValidD;
            bestIDQ    <= bestIDD;
            bestQQ     <= bestQD;
            numValidQ  <= numValidD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        tblD       = tblQ;
        cntD       = cntQ;
        srcIDD     = srcIDQ;
        srcEnergyD = srcEnergyQ;
        srcHopsD   = srcHopsQ;
        srcQD      = srcQQ;
        srcLowED   = srcLowEQ;
        hitD       = hitQ;
        freeFoundD = freeFoundQ;
        slotD      = slotQ;
        dropD      = dropQ;
        runValidD  = runValidQ;
        runIDD     = runIDQ;
        runQvalD   = runQvalQ;
        runCntD    = runCntQ;
        bestValidD = bestValidQ;
        bestIDD    = bestIDQ;
        bestQD     = bestQQ;
        numValidD  = numValidQ;
        curEntry   = tblQ[idx];
        qOld       = hitQ ? tblQ[slotQ].q : INIT_Q;

        unique case (stateQ)
            IDLE: begin
                cntD = '0;
                if (tblClear_i) begin
                    for (int i = 0; i < NUM_NEIGHBORS; i++) begin
                        tblD[i].valid = 1'b0;
                    end
                    bestValidD = 1'b0;
                    bestIDD    = '0;
                    bestQD     = '0;
                    numValidD  = '0;
                end else if (accept) begin
                    srcIDD     = bus.srcID;
                    srcEnergyD = bus.srcEnergy;
                    srcHopsD   = bus.srcHops;
                    srcQD      = bus.srcQ;
                    srcLowED   = bus.srcLowE;
                    hitD       = 1'b0;
                    freeFoundD = 1'b0;
                    slotD      = '0;
                    dropD      = 1'b0;
                    if (!typeEnabled(UPDATE_TYPE_MASK, bus.fPacketType) ||
                        (bus.srcID == myNodeID_i)) begin
                        dropD  = 1'b1;
                        stateD = DONE;
                    end else begin
                        stateD = SEARCH;
                    end
                end
            end

            SEARCH: begin
                if (curEntry.valid && (curEntry.id == srcIDQ)) begin
                    hitD   = 1'b1;
                    slotD  = idx;
                    stateD = UPDATE;
                end else begin
                    if (!curEntry.valid && !freeFoundQ) begin
                        freeFoundD = 1'b1;
                        slotD      = idx;
                    end
                    if (cntQ == LAST_IDX) begin
                        stateD = UPDATE;
                    end else begin
                        cntD = cntQ + 1'b1;
                    end
                end
            end

            UPDATE: begin
                if (hitQ) begin
                    tblD[slotQ].q = qNew;
                end else if (freeFoundQ) begin
                    tblD[slotQ] = '{valid: 1'b1, id: srcIDQ, q: qNew};
                end else begin
                    dropD = 1'b1;
                end
                cntD      = '0;
                runValidD = 1'b0;
                runIDD    = '0;
                runQvalD  = '0;
                runCntD   = '0;
                stateD    = BEST;
            end

            // One extra cycle past the last entry commits the running result
            BEST: begin
                if (cntQ == SCAN_END) begin
                    bestValidD = runValidQ;
                    bestIDD    = runIDQ;
                    bestQD     = runQvalQ;
                    numValidD  = runCntQ;
                    stateD     = DONE;
                end else begin
                    if (curEntry.valid) begin
                        runCntD = runCntQ + 1'b1;
                        if (!runValidQ || (curEntry.q > runQvalQ)) begin
                            runValidD = 1'b1;
                            runIDD    = curEntry.id;
                            runQvalD  = curEntry.q;
                        end
                    end
                    cntD = cntQ + 1'b1;
                end
            end

            DONE: begin
                stateD = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign bus.pktReady  = armedQ && (stateQ == IDLE) && en_i && !tblClear_i;
    assign bus.updDone   = (stateQ == DONE);
    assign bus.updDrop   = (stateQ == DONE) && dropQ;
    assign bus.bestValid = bestValidQ;
    assign bus.bestID    = bestIDQ;
    assign bus.bestQ     = bestQQ;
    assign bus.numValid  = numValidQ;
    assign bus.tblFull   = (numValidQ == SCAN_END);

endmodule

// File: tb/tb_reward_qtable.sv
// Self-checking bench for reward_qtable: directed scenarios then random packets,
// all compared against an array-based behavioural model of the neighbour table.
module tb_reward_qtable;

    localparam int N     = 8;
    localparam int WW    = 16;
    localparam int MAXW  = 65535;
    localparam int MY_ID = 99;
    localparam logic [7:0] MASK = 8'h0A;

    logic clk;
    logic rst_n;
    logic en;
    logic tblClear;
    logic [WW-1:0] myNodeID;

    reward_qtable_if #(.WW(WW), .NUM_NEIGHBORS(N)) bus ();

    reward_qtable #(
        .NUM_NEIGHBORS (N),
        .WORD_WIDTH    (WW),
        .E_SHIFT       (4),
        .HOP_SHIFT     (3),
        .ALPHA_SHIFT   (1),
        .INIT_Q        (16'd0),
        .UPDATE_TYPE_MASK (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .tblClear_i (tblClear),
        .myNodeID_i (myNodeID),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errCount   = 0;

    bit modelValid [N];
    int modelId    [N];
    int modelQ     [N];
    bit pubValid;
    int pubId;
    int pubQ;
    int pubCnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int rewardOf(input int e, input int hops, input bit lowE);
        int eT;
        int hT;
        eT = e / 16;
        hT = hops * 8;
        if (hT > MAXW) hT = MAXW;
        if (lowE || eT <= hT) return 0;
        return eT - hT;
    endfunction

    function automatic int qUpdate(input int qOld, input int target);
        int diff;
        diff = target - qOld;
        if (diff >= 0) return qOld + diff / 2;
        return qOld - ((-diff + 1) / 2);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < N; i++) begin
            modelValid[i] = 1'b0;
            modelId[i]    = 0;
            modelQ[i]     = 0;
        end
        pubValid = 1'b0;
        pubId    = 0;
        pubQ     = 0;
        pubCnt   = 0;
    endtask

    task automatic modelPublish();
        pubValid = 1'b0;
        pubId    = 0;
        pubQ     = 0;
        pubCnt   = 0;
        for (int i = 0; i < N; i++) begin
            if (modelValid[i]) begin
                pubCnt++;
                if (!pubValid || modelQ[i] > pubQ) begin
                    pubValid = 1'b1;
                    pubId    = modelId[i];
                    pubQ     = modelQ[i];
                end
            end
        end
    endtask

    task automatic checkPublished();
        checkOutput("bestValid", bus.bestValid, pubValid);
        checkOutput("bestID", bus.bestID, pubId);
        checkOutput("bestQ", bus.bestQ, pubQ);
        checkOutput("numValid", bus.numValid, pubCnt);
        checkOutput("tblFull", bus.tblFull, pubCnt == N);
    endtask

    task automatic checkAllZero();
        checkOutput("rst_pktReady", bus.pktReady, 0);
        checkOutput("rst_updDone", bus.updDone, 0);
        checkOutput("rst_updDrop", bus.updDrop, 0);
        checkOutput("rst_bestValid", bus.bestValid, 0);
        checkOutput("rst_bestID", bus.bestID, 0);
        checkOutput("rst_bestQ", bus.bestQ, 0);
        checkOutput("rst_numValid", bus.numValid, 0);
        checkOutput("rst_tblFull", bus.tblFull, 0);
    endtask

    task automatic waitReady();
        int waitCnt;
        waitCnt = 0;
        while (bus.pktReady !== 1'b1 && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("pktReady_wait", bus.pktReady, 1);
    endtask

    task automatic clearTable();
        waitReady();
        tblClear = 1'b1;
        @(posedge clk); #1;
        tblClear = 1'b0;
        modelClear();
        checkOutput("clr_numValid", bus.numValid, 0);
        checkOutput("clr_bestValid", bus.bestValid, 0);
    endtask

    // Sends one packet, predicts drop/latency/table effect, and optionally drops en or
    // pulses reset at a given cycle offset after acceptance.
    task automatic applyStimulus(input logic [2:0] ptype, input int id, input int e, input int hops,
                                 input int sq, input bit lowE, input int dropEnAt, input int abortAt);
        bit typeDrop;
        bit expDrop;
        int hitIdx;
        int freeIdx;
        int expLat;
        int cycles;
        int qNew;
        int target;
        bit seen;
        bit aborted;

        waitReady();
        bus.pktValid    = 1'b1;
        bus.fPacketType = ptype;
        bus.srcID       = 16'(id);
        bus.srcEnergy   = 16'(e);
        bus.srcHops     = 16'(hops);
        bus.srcQ        = 16'(sq);
        bus.srcLowE     = lowE;

        typeDrop = !MASK[ptype] || (id == MY_ID);
        hitIdx   = -1;
        freeIdx  = -1;
        for (int i = 0; i < N; i++) begin
            if (hitIdx < 0 && modelValid[i] && modelId[i] == id) hitIdx = i;
            if (freeIdx < 0 && !modelValid[i]) freeIdx = i;
        end
        expDrop = typeDrop || (hitIdx < 0 && freeIdx < 0);
        if (typeDrop)        expLat = 1;
        else if (hitIdx >= 0) expLat = hitIdx + N + 4;
        else                 expLat = 2 * N + 3;

        @(posedge clk); #1;
        bus.pktValid = 1'b0;
        cycles  = 1;
        seen    = 1'b0;
        aborted = 1'b0;
        while (!seen && !aborted && cycles <= 3 * N + 10) begin
            if (cycles == dropEnAt) en = 1'b0;
            if (cycles == abortAt) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end else if (bus.updDone === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cycles++;
            end
        end

        if (aborted) begin
            #1;
            checkAllZero();
            modelClear();
        end else begin
            checkOutput("updDone_latency", cycles, expLat);
            checkOutput("updDrop", bus.updDrop, expDrop);
            if (!typeDrop) begin
                target = rewardOf(e, hops, lowE) + sq;
                if (target > MAXW) target = MAXW;
                if (hitIdx >= 0) begin
                    modelQ[hitIdx] = qUpdate(modelQ[hitIdx], target);
                end else if (freeIdx >= 0) begin
                    qNew = qUpdate(0, target);
                    modelValid[freeIdx] = 1'b1;
                    modelId[freeIdx]    = id;
                    modelQ[freeIdx]     = qNew;
                end
                modelPublish();
            end
            checkPublished();
            @(posedge clk); #1;
            if (dropEnAt > 0) checkOutput("pktReady_enLow", bus.pktReady, 0);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        en              = 1'b1;
        tblClear        = 1'b0;
        myNodeID        = 16'(MY_ID);
        bus.pktValid    = 1'b0;
        bus.fPacketType = 3'd0;
        bus.srcID       = '0;
        bus.srcEnergy   = '0;
        bus.srcHops     = '0;
        bus.srcQ        = '0;
        bus.srcLowE     = 1'b0;
        modelClear();

        repeat (3) @(posedge clk);
        #1;
        checkAllZero();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", bus.pktReady, 1);

        // First learn of a neighbour, then a repeat that hits index 0
        applyStimulus(3'd1, 5, 1600, 2, 100, 1'b0, -1, -1);
        checkOutput("s1_bestQ", bus.bestQ, 92);
        checkOutput("s1_bestID", bus.bestID, 5);
        applyStimulus(3'd1, 5, 1600, 2, 100, 1'b0, -1, -1);
        checkOutput("s2_bestQ", bus.bestQ, 138);

        // Zero-reward and saturating-target corners
        clearTable();
        applyStimulus(3'd3, 10, 32, 5, 50, 1'b0, -1, -1);
        checkOutput("s3_zeroR_bestQ", bus.bestQ, 25);
        applyStimulus(3'd3, 11, 1600, 2, 40, 1'b1, -1, -1);
        checkOutput("s3_lowE_bestQ", bus.bestQ, 25);
        applyStimulus(3'd1, 12, 1600, 0, 16'hFFF0, 1'b0, -1, -1);
        checkOutput("s3_sat_bestQ", bus.bestQ, 32767);

        // Fill the table, overflow it, then clear
        clearTable();
        for (int i = 0; i < N; i++) applyStimulus(3'd1, 21 + i, 800, 1, i * 10, 1'b0, -1, -1);
        applyStimulus(3'd1, 30, 4000, 0, 60000, 1'b0, -1, -1);
        checkOutput("s4_full_drop", bus.updDrop === 1'b0 && bus.tblFull === 1'b1, 1);
        clearTable();

        applyStimulus(3'd2, 7, 1600, 2, 100, 1'b0, -1, -1);
        applyStimulus(3'd1, MY_ID, 1600, 2, 100, 1'b0, -1, -1);

        // Tie on Q at indices 2 and 5 resolves to the lower index
        clearTable();
        for (int i = 0; i < 6; i++)
            applyStimulus(3'd1, 41 + i, 0, 0, (i == 2 || i == 5) ? 1000 : 100, 1'b0, -1, -1);
        checkOutput("s6_tie_bestID", bus.bestID, 43);
        applyStimulus(3'd1, 47, 500, 1, 20, 1'b0, 2, -1);
        en = 1'b1;
        applyStimulus(3'd1, 48, 500, 1, 20, 1'b0, -1, N + 5);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            logic [2:0] ptype;
            int id;
            int hops;
            if (n % 17 == 16) clearTable();
            ptype = ($urandom_range(0, 9) < 7) ? (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd3)
                                               : 3'($urandom_range(0, 7));
            id    = ($urandom_range(0, 19) == 0) ? MY_ID : int'($urandom_range(1, 12));
            hops  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8000, 65535))
                                                : int'($urandom_range(0, 40));
            applyStimulus(ptype, id, int'($urandom_range(0, 65535)), hops,
                          int'($urandom_range(0, 65535)), ($urandom_range(0, 4) == 0), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
